// File: rtl/rv32_alu.sv
// -----------------------------------------------------------------------------
// rv32_alu
//
// RV32 base-integer ALU for the execute stage. One of ten operations is
// computed combinationally on o_c/o_zero in the same cycle; a registered copy
// with a valid flag is offered for pipelined consumers.
//
// Optional feature macro: ALU_SLTU_EN
//   defined   : opcode 0x0A performs SLTU (unsigned set-less-than)
//   undefined : opcode 0x0A is an undefined opcode and yields o_c = 0
//
// Parameters:
//   DATA_WIDTH  operand/result width (power of two, >= 8)
//   SHAMT_W     shift-amount width taken from the low bits of i_b
//
// Ports:
//   i_clk     in   1           clock, rising edge
//   i_rst_n   in   1           asynchronous active-low reset (registered path only)
//   i_alu_op  in   6           operation select
//   i_a       in   DATA_WIDTH  operand A
//   i_b       in   DATA_WIDTH  operand B / shift amount
//   i_valid   in   1           operands valid; captures result into output register
//   o_c       out  DATA_WIDTH  combinational result
//   o_zero    out  1           combinational, 1 when o_c == 0
//   o_c_q     out  DATA_WIDTH  registered result
//   o_zero_q  out  1           registered zero flag
//   o_valid   out  1           registered i_valid
// -----------------------------------------------------------------------------
module rv32_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [5:0]            i_alu_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_c,
    output logic                  o_zero,
    output logic [DATA_WIDTH-1:0] o_c_q,
    output logic                  o_zero_q,
    output logic                  o_valid
);

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_SLT  = 6'h05;
    localparam logic [5:0] OP_SLL  = 6'h06;
    localparam logic [5:0] OP_SRL  = 6'h07;
    localparam logic [5:0] OP_SRA  = 6'h08;
    localparam logic [5:0] OP_INV  = 6'h09;
`ifdef ALU_SLTU_EN
    localparam logic [5:0] OP_SLTU = 6'h0A;
`endif

    // Compare results are a single bit placed in the LSB, zero-extended.
    function automatic logic [DATA_WIDTH-1:0] flag_ext(input logic f);
        flag_ext = {{(DATA_WIDTH-1){1'b0}}, f};
    endfunction

    // Signed views of the operands so SLT and SRA use signed semantics.
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic        [SHAMT_W-1:0]    shamt;

    assign a_s   = i_a;
    assign b_s   = i_b;
    // Bits of i_b above SHAMT_W are deliberately ignored (RV32 shamt semantics).
    assign shamt = i_b[SHAMT_W-1:0];

    logic [DATA_WIDTH-1:0] c;

    always_comb begin
        c = '0;
        unique case (i_alu_op)
            OP_ADD:  c = i_a + i_b;
            OP_SUB:  c = i_a - i_b;
            OP_AND:  c = i_a & i_b;
            OP_OR:   c = i_a | i_b;
            OP_XOR:  c = i_a ^ i_b;
            OP_SLT:  c = flag_ext(a_s < b_s);
            OP_SLL:  c = i_a << shamt;
            OP_SRL:  c = i_a >> shamt;
            OP_SRA:  c = a_s >>> shamt;
            OP_INV:  c = ~i_a;
`ifdef ALU_SLTU_EN
            OP_SLTU: c = flag_ext(i_a < i_b);
`endif
            default: c = '0;
        endcase
    end

    assign o_c    = c;
    assign o_zero = (c == '0);

    // ---- registered output stage ----
    logic [DATA_WIDTH-1:0] c_q,    c_d;
    logic                  zero_q, zero_d;
    logic                  valid_q, valid_d;

    // Result and flag only update on a valid cycle; otherwise they hold.
    always_comb begin
        c_d     = c_q;
        zero_d  = zero_q;
        valid_d = i_valid;
        if (i_valid) begin
            c_d    = c;
            zero_d = o_zero;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c_q     <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign o_c_q    = c_q;
    assign o_zero_q = zero_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_rv32_alu.sv
module tb_rv32_alu;

    logic        clk;
    logic        rst_n;
    logic [5:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
    logic [31:0] c;
    logic        zero;
    logic [31:0] c_q;
    logic        zero_q;
    logic        vld_q;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb[$];
    logic [31:0] held;

    rv32_alu #(.DATA_WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_alu_op (alu_op),
        .i_a      (a),
        .i_b      (b),
        .i_valid  (valid),
        .o_c      (c),
        .o_zero   (zero),
        .o_c_q    (c_q),
        .o_zero_q (zero_q),
        .o_valid  (vld_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference model.
    function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ext;
        logic [4:0]  sh;
        sh = y[4:0];
        case (op)
            6'h00: model = x + y;
            6'h01: model = x + (~y) + 32'd1;
            6'h02: model = x & y;
            6'h03: model = x | y;
            6'h04: model = x ^ y;
            6'h05: model = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            6'h06: model = x << sh;
            6'h07: model = x >> sh;
            6'h08: begin
                ext   = {{32{x[31]}}, x} >> sh;
                model = ext[31:0];
            end
            6'h09: model = ~x;
`ifdef ALU_SLTU_EN
            6'h0A: model = (x < y) ? 32'd1 : 32'd0;
`endif
            default: model = 32'd0;
        endcase
    endfunction

    // Drive one operation, check the combinational result, then check the
    // registered path one edge later against the scoreboard.
    task automatic step(input string tag, input logic [5:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic v, input logic [31:0] exp_c);
        logic [31:0] e;
        @(negedge clk);
        alu_op = op;
        a      = x;
        b      = y;
        valid  = v;
        #1;
        check({tag, ".c"}, c, exp_c);
        check({tag, ".zero"}, 32'(zero), 32'(exp_c == 32'd0));
        if (v) sb.push_back(exp_c);
        @(posedge clk);
        #1;
        check({tag, ".valid_q"}, 32'(vld_q), 32'(v));
        if (vld_q) begin
            if (sb.size() == 0) begin
                check({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({tag, ".c_q"}, c_q, e);
                check({tag, ".zero_q"}, 32'(zero_q), 32'(e == 32'd0));
                held = e;
            end
        end else begin
            check({tag, ".c_q_hold"}, c_q, held);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [5:0]  rop;
        logic [5:0]  ops[5];
        ops[0] = 6'h00; ops[1] = 6'h01; ops[2] = 6'h04; ops[3] = 6'h05; ops[4] = 6'h08;

        rst_n  = 1'b0;
        alu_op = 6'h00;
        a      = 32'd0;
        b      = 32'd0;
        valid  = 1'b0;
        held   = 32'd0;

        #2;
        check("rst.c_q", c_q, 32'd0);
        check("rst.zero_q", 32'(zero_q), 32'd0);
        check("rst.valid", 32'(vld_q), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Combinational ops
        step("inv",      6'h09, 32'h1,          32'h0,          1'b1, 32'hFFFF_FFFE);
        step("add",      6'h00, 32'h1,          32'h1,          1'b1, 32'h2);
        step("sub0",     6'h01, 32'h1,          32'h1,          1'b1, 32'h0);
        step("addwrap",  6'h00, 32'hFFFF_FFFF,  32'h1,          1'b1, 32'h0);
        // Logic / compare
        step("and",      6'h02, 32'h0000_0101,  32'h0001_0001,  1'b1, 32'h1);
        step("or",       6'h03, 32'h0000_0101,  32'h0001_0001,  1'b1, 32'h0001_0101);
        step("xor",      6'h04, 32'h0000_0101,  32'h0001_0001,  1'b1, 32'h0001_0100);
        step("slt",      6'h05, 32'h0000_0101,  32'h0001_0001,  1'b1, 32'h1);
        step("sltneg",   6'h05, 32'h8000_0000,  32'h1,          1'b1, 32'h1);
        step("sltfalse", 6'h05, 32'h1,          32'h8000_0000,  1'b1, 32'h0);
        step("sltu_a",   6'h0A, 32'h8000_0000,  32'h1,          1'b1, 32'h0);
`ifdef ALU_SLTU_EN
        step("sltu_b",   6'h0A, 32'h1,          32'h2,          1'b1, 32'h1);
`else
        step("sltu_b",   6'h0A, 32'h1,          32'h2,          1'b1, 32'h0);
`endif
        // Shifts
        step("sll",      6'h06, 32'h1,          32'h10,         1'b1, 32'h0001_0000);
        step("srl",      6'h07, 32'h100,        32'h1,          1'b1, 32'h80);
        step("sra",      6'h08, 32'hFFFF_FFF0,  32'h3,          1'b1, 32'hFFFF_FFFE);
        step("sra31",    6'h08, 32'h8000_0000,  32'h1F,         1'b1, 32'hFFFF_FFFF);
        step("sllwrap",  6'h06, 32'h1,          32'h21,         1'b1, 32'h2);
        step("sll0",     6'h06, 32'h1234_5678,  32'h20,         1'b1, 32'h1234_5678);
        // Undefined opcode
        step("undef",    6'h3F, 32'hDEAD_BEEF,  32'h1234_5678,  1'b1, 32'h0);

        // Registered path: capture then hold
        step("reg_add",  6'h00, 32'd2,          32'd3,          1'b1, 32'd5);
        step("reg_hold", 6'h00, 32'd7,          32'd8,          1'b0, 32'd15);

        // Random operations against the reference model
        for (int i = 0; i < 10; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = ops[$urandom_range(0, 4)];
            step("rand", rop, ra, rb, 1'b1, model(rop, ra, rb));
        end

        // Load a nonzero registered value, then reset asynchronously between edges
        step("pre_rst",  6'h03, 32'hA5A5_0000,  32'h0000_5A5A,  1'b1, 32'hA5A5_5A5A);
        @(negedge clk);
        alu_op = 6'h00; a = 32'd7; b = 32'd8; valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.c_q", c_q, 32'd0);
        check("async_rst.zero_q", 32'(zero_q), 32'd0);
        check("async_rst.valid", 32'(vld_q), 32'd0);
        check("rst_comb.c", c, 32'd15);
        a = 32'd100;
        #1;
        check("rst_comb.track", c, 32'd108);
        @(posedge clk);
        #1;
        check("rst_hold.valid", 32'(vld_q), 32'd0);
        check("rst_hold.c_q", c_q, 32'd0);
        sb.delete();
        held = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // First capture after release
        step("post_rst", 6'h01, 32'd10,         32'd4,          1'b1, 32'd6);
        step("post_idle",6'h09, 32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
